// File: rtl/master_rx_burst_engine.sv
// Master-side serial receive engine: deserialises slave bit streams into words for a
// programmable-length burst and queues them in a small valid/ready output FIFO.
module master_rx_burst_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_W    = 12,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [BURST_W-1:0]            burst_num,
  input  logic                          slave_valid,
  input  logic                          rx_data,
  output logic                          master_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          rx_done,
  output logic                          timeout_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HANDSHAKE, RECEIVE} state_t;

  state_t                  state_reg, state_next;
  logic [BURST_W-1:0]      burst_reg, word_cnt_reg;
  logic [BW-1:0]           bit_cnt_reg;
  logic [TW-1:0]           timeout_cnt_reg;
  logic [DATA_WIDTH-1:0]   shift_reg, shift_next, shift_base;
  logic                    rx_done_reg, timeout_err_reg;
  logic [LW-1:0]           level_reg;
  logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];

  logic          hs_fire, to_inc, to_expire, last_bit, burst_end, push, pop;
  logic [BW-1:0] bit_k, bit_pos;

  assign hs_fire   = (state_reg == HANDSHAKE) && master_ready && slave_valid;
  assign to_inc    = (state_reg == HANDSHAKE) && master_ready && !slave_valid;
  assign to_expire = to_inc && (timeout_cnt_reg == TW'(TIMEOUT - 1));
  assign last_bit  = (state_reg == RECEIVE) && (bit_cnt_reg == BW'(DATA_WIDTH - 1));
  assign burst_end = last_bit && (word_cnt_reg == burst_reg);
  assign push      = last_bit;
  assign pop       = out_valid && out_ready;

  // Serial bit k lands at k, or mirrored when MSB_FIRST; a handshake starts a fresh word.
  assign bit_k      = hs_fire ? '0 : bit_cnt_reg;
  assign bit_pos    = MSB_FIRST ? BW'(DATA_WIDTH - 1) - bit_k : bit_k;
  assign shift_base = hs_fire ? '0 : shift_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_insert
      assign shift_next[gi] = (bit_pos == BW'(gi)) ? rx_data : shift_base[gi];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    master_ready = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = HANDSHAKE;
      HANDSHAKE: begin
        // The in-flight word's FIFO slot is reserved before the handshake is offered.
        master_ready = (level_reg < LW'(FIFO_DEPTH));
        if (master_ready && slave_valid) state_next = RECEIVE;
        else if (to_expire)              state_next = IDLE;
      end
      RECEIVE: if (last_bit) state_next = burst_end ? IDLE : HANDSHAKE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      burst_reg       <= '0;
      word_cnt_reg    <= '0;
      bit_cnt_reg     <= '0;
      timeout_cnt_reg <= '0;
      shift_reg       <= '0;
      rx_done_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
      level_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      rx_done_reg     <= burst_end;
      timeout_err_reg <= to_expire;
      if ((state_reg == IDLE) && start) begin
        burst_reg       <= burst_num;
        word_cnt_reg    <= '0;
        timeout_cnt_reg <= '0;
      end
      if (hs_fire) begin
        bit_cnt_reg     <= BW'(1);
        timeout_cnt_reg <= '0;
        shift_reg       <= shift_next;
      end else if (to_inc) begin
        timeout_cnt_reg <= to_expire ? '0 : timeout_cnt_reg + TW'(1);
      end
      if (state_reg == RECEIVE) begin
        shift_reg   <= shift_next;
        bit_cnt_reg <= last_bit ? '0 : bit_cnt_reg + BW'(1);
        if (last_bit && !burst_end) word_cnt_reg <= word_cnt_reg + BURST_W'(1);
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      level_reg <= level_reg + LW'(1);
      else if (pop && !push) level_reg <= level_reg - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= shift_next;
  end

  assign out_valid   = (level_reg != '0);
  assign out_data    = out_valid ? mem[rd_ptr_reg] : '0;
  assign fifo_level  = level_reg;
  assign rx_done     = rx_done_reg;
  assign timeout_err = timeout_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_master_rx_burst_engine.sv
// Directed bench: an LSB-first and an MSB-first engine share stimulus; each step checks
// against hand-computed values with immediate assertions.
module tb_master_rx_burst_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [11:0] burst_num = '0;
  logic        slave_valid = 1'b0;
  logic        rx_data = 1'b0;
  logic        out_ready = 1'b0;

  logic       mr0, ov0, done0, terr0, busy0, mr1, ov1, done1, terr1, busy1;
  logic [7:0] od0, od1;
  logic [2:0] lvl0, lvl1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  master_rx_burst_engine #(.MSB_FIRST(1'b0), .TIMEOUT(10)) dut0 (
    .clk(clk), .reset(reset), .start(start), .burst_num(burst_num),
    .slave_valid(slave_valid), .rx_data(rx_data), .master_ready(mr0),
    .out_valid(ov0), .out_data(od0), .out_ready(out_ready), .rx_done(done0),
    .timeout_err(terr0), .busy(busy0), .fifo_level(lvl0));

  master_rx_burst_engine #(.MSB_FIRST(1'b1), .TIMEOUT(10)) dut1 (
    .clk(clk), .reset(reset), .start(start), .burst_num(burst_num),
    .slave_valid(slave_valid), .rx_data(rx_data), .master_ready(mr1),
    .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .rx_done(done1),
    .timeout_err(terr1), .busy(busy1), .fifo_level(lvl1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [11:0] n);
    start = 1'b1;
    burst_num = n;
    tick();
    start = 1'b0;
  endtask

  // Serial bit k of the transfer is w[k].
  task automatic send_word(input logic [7:0] w);
    slave_valid = 1'b1;
    rx_data = w[0];
    tick();
    slave_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      rx_data = w[k];
      tick();
    end
    rx_data = 1'b0;
    $display("word sent serial(LSB-of-vector first)=%02h lvl0=%0d od0=%02h od1=%02h done=%0b",
             w, lvl0, od0, od1, done0);
  endtask

  initial begin
    int ready_cycles;
    int guard;
    logic saw_err;

    // Reset state
    reset = 1'b1;
    #1;
    check("rst_master_ready", mr0, 0);
    check("rst_out_valid", ov0, 0);
    check("rst_out_data", od0, 0);
    check("rst_busy", busy0, 0);
    check("rst_level", lvl0, 0);
    check("rst_flags", {done0, terr0}, 0);
    tick();
    reset = 1'b0;
    tick();

    // LSB-first single word: serial 1,0,1,0,0,1,0,1
    do_start(12'd0);
    check("t1_busy", busy0, 1);
    check("t1_master_ready", mr0, 1);
    send_word(8'hA5);
    check("t1_out_valid", ov0, 1);
    check("t1_out_data", od0, 8'hA5);
    check("t1_msb_data", od1, 8'hA5);
    check("t1_rx_done", done0, 1);
    check("t1_idle", busy0, 0);
    tick();
    check("t1_done_pulse", done0, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_popped", ov0, 0);

    // Bit order: serial 1,1,0,0,0,0,0,0
    do_start(12'd0);
    send_word(8'h03);
    check("t2_lsb_first", od0, 8'h03);
    check("t2_msb_first", od1, 8'hC0);
    check("t2_done_msb", done1, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Burst of three with a consumer always ready
    out_ready = 1'b1;
    do_start(12'd2);
    send_word(8'h11);
    check("t3_w0", od0, 8'h11);
    check("t3_w0_no_done", done0, 0);
    check("t3_w0_busy", busy0, 1);
    send_word(8'h22);
    check("t3_w1", od0, 8'h22);
    check("t3_w1_level", lvl0, 1);
    send_word(8'h33);
    check("t3_w2", od0, 8'h33);
    check("t3_done", done0, 1);
    tick();
    check("t3_drained", ov0, 0);
    check("t3_done_pulse", done0, 0);
    out_ready = 1'b0;

    // Backpressure: six words into a four-entry FIFO
    do_start(12'd5);
    for (int i = 0; i < 4; i++) send_word(8'h41 + 8'(i));
    check("t4_level_full", lvl0, 4);
    check("t4_ready_low", mr0, 0);
    saw_err = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      saw_err = saw_err | terr0 | !busy0 | mr0;
    end
    check("t4_stall_no_timeout", saw_err, 0);
    check("t4_head_stable", od0, 8'h41);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_level_after_pop", lvl0, 3);
    check("t4_ready_again", mr0, 1);
    send_word(8'h45);
    check("t4_level_w5", lvl0, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send_word(8'h46);
    check("t4_done", done0, 1);
    check("t4_level_final", lvl0, 4);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_drain%0d", i), od0, 8'h43 + 8'(i));
      tick();
    end
    check("t4_empty", ov0, 0);
    out_ready = 1'b0;

    // Timeout with the slave silent
    do_start(12'd0);
    ready_cycles = 0;
    guard = 0;
    while (!terr0 && guard < 50) begin
      if (mr0) ready_cycles++;
      tick();
      guard++;
    end
    check("t5_timeout_seen", terr0, 1);
    check("t5_ready_cycles", ready_cycles, 10);
    check("t5_idle", busy0, 0);
    check("t5_no_done", done0, 0);
    tick();
    check("t5_err_pulse", terr0, 0);

    // Reset in the middle of the second word
    do_start(12'd1);
    send_word(8'h5A);
    check("t6_one_word", lvl0, 1);
    slave_valid = 1'b1;
    rx_data = 1'b1;
    tick();
    slave_valid = 1'b0;
    for (int k = 1; k <= 3; k++) tick();
    reset = 1'b1;
    #1;
    check("t6_level", lvl0, 0);
    check("t6_out_valid", ov0, 0);
    check("t6_master_ready", mr0, 0);
    check("t6_busy", busy0, 0);
    #2;
    reset = 1'b0;
    tick();
    do_start(12'd0);
    send_word(8'h96);
    check("t6_new_word", od0, 8'h96);
    check("t6_new_done", done0, 1);
    check("t6_new_level", lvl0, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/master_rx_burst_engine.md
Name: master_rx_burst_engine

Overview:
- Parametrised next-generation serial receive engine for the master side of the system bus.
- Deserialises bit-serial slave data into DATA_WIDTH-bit words, one per handshake, for a burst of programmable length.
- Buffers received words in an internal FIFO with a valid/ready output. Provides bit-order selection, handshake timeout and backpressure toward the slave.
- Sits between the slave bus interface and the master's read-data consumer. Started by the master-out side once a read request has been sent.

Parameters:
DATA_WIDTH, 8, bits per received word (>=2)
BURST_W, 12, width of burst_num
FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2)
MSB_FIRST, 0, 0: first serial bit lands in bit 0; 1: first bit lands in bit DATA_WIDTH-1
TIMEOUT, 255, max cycles HANDSHAKE waits for slave_valid (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a read burst; honoured only in IDLE
burst_num  input  BURST_W  words in burst minus 1; latched on accepted start
slave_valid  input  1  slave presents a valid first bit this cycle
rx_data  input  1  serial data from slave
master_ready  output  1  master can accept a word (handshake partner of slave_valid)
out_valid  output  1  FIFO head word valid
out_data  output  DATA_WIDTH  FIFO head word
out_ready  input  1  consumer accepts head word when out_valid=1
rx_done  output  1  one-cycle pulse: full burst received
timeout_err  output  1  one-cycle pulse: burst aborted on handshake timeout
busy  output  1  high when state != IDLE
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (clk ignored): state=IDLE. master_ready=0, out_valid=0, out_data=0, rx_done=0, timeout_err=0, busy=0, fifo_level=0. Shift register, bit/word/timeout counters cleared. FIFO flushed. An in-flight word is discarded.
- States: IDLE, HANDSHAKE, RECEIVE.
- IDLE:
  - start=1 -> latch burst_num, clear word and timeout counters, go to HANDSHAKE.
  - start is ignored in all other states.
- HANDSHAKE:
  - master_ready = (fifo_level < FIFO_DEPTH), combinational from registered level. A slot is reserved for the in-flight word.
  - master_ready&&slave_valid -> sample rx_data as serial bit 0, bit counter=1, clear timeout counter, go to RECEIVE.
  - Otherwise, the timeout counter increments only while master_ready=1; FIFO-full stall cycles do not count.
  - Counter reaching TIMEOUT -> pulse timeout_err, go to IDLE. Words already in the FIFO remain and drain normally. rx_done is not asserted.
- RECEIVE:
  - master_ready=0. One rx_data bit is sampled per cycle; slave_valid is ignored.
  - Serial bit k is placed at index k (MSB_FIRST=0) or DATA_WIDTH-1-k (MSB_FIRST=1).
  - On the cycle bit DATA_WIDTH-1 is sampled, the complete word, including that last bit, is pushed to the FIFO.
  - If the word count equals latched burst_num, pulse rx_done in the next cycle and go to IDLE. Otherwise increment the word count and go to HANDSHAKE.
- Latency:
  - A word appears on out_valid/out_data the cycle after its last bit is sampled.
  - rx_done asserts in the same cycle the final word becomes visible.
  - Minimum spacing is DATA_WIDTH cycles per word.
- FIFO:
  - out_valid = (fifo_level != 0). out_data = head word, stable while out_valid=1 and out_ready=0.
  - A pop occurs on out_valid&&out_ready.
  - Simultaneous push and pop leaves the level unchanged, including when full.
  - Overflow is impossible by the reservation rule.
  - Pop when empty has no effect.
- Widths:
  - Word counter is BURST_W bits and compares for equality, so burst_num = all-ones yields 2^BURST_W words.
  - Timeout counter is sized to hold TIMEOUT.
- rx_done and timeout_err are never high in the same cycle. busy tracks state, not FIFO contents.

Test Plan:
- LSB-first single word:
  - Stimulus: MSB_FIRST=0, burst_num=0, start. Slave asserts valid and sends serial 1,0,1,0,0,1,0,1.
  - Response: out_data=0xA5, out_valid 1 cycle after bit 7. rx_done pulse in the same cycle. Back to IDLE.
- MSB-first:
  - Stimulus: MSB_FIRST=1, same serial sequence.
  - Response: out_data=0xA5 reversed = 0xA5 for palindromic stimulus, so also send 1,1,0,0,0,0,0,0.
  - Required result: 0xC0, whereas MSB_FIRST=0 gives 0x03.
- Burst:
  - Stimulus: burst_num=2, out_ready=1, slave sends 0x11, 0x22, 0x33 back-to-back.
  - Response: three handshakes, three out_valid words in order. Single rx_done after the third word.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4, burst_num=5, out_ready=0.
  - Response: after 4 words, fifo_level=4 and master_ready stays 0 with no timeout.
  - Then raise out_ready for 1 cycle: master_ready=1 next cycle, and the remaining 2 words complete.
- Timeout:
  - Stimulus: TIMEOUT=10, start, slave_valid held 0.
  - Response: timeout_err pulse after exactly 10 master_ready-high cycles. State IDLE, rx_done=0.
- Reset mid-word:
  - Stimulus: assert reset after bit 3 of word 2, with 1 word in the FIFO.
  - Response: fifo_level=0, out_valid=0, master_ready=0, busy=0 immediately.
  - A new start then receives correctly.
